// File: rtl/program_loader.sv
// rtl/program_loader.sv - framed byte-stream loader that fills instruction memory and gates CPU reset
//
// Purpose:
//   Receives a program image as a byte stream and writes it into the instruction store.
//   The frame is: N (2 bytes, big-endian), N records of 4 bytes each
//   (opcode hi/lo, operand hi/lo), and one checksum byte. The checksum is the XOR of
//   every earlier frame byte. The processor is held in reset until a frame with a good
//   checksum has been fully written.
//
// Ports:
//   clk          - system clock; all state changes on the rising edge
//   reset        - asynchronous, active-high reset
//   in_data      - image byte; used only when in_valid && in_ready
//   in_valid     - in_data is valid
//   in_ready     - loader can accept a byte this cycle (a decode of the state)
//   reload       - single-cycle pulse; restarts loading from DONE or ERROR
//   imem_we      - instruction memory write strobe (high only in the WRITE cycle)
//   imem_addr    - write address / slot counter
//   imem_opcode  - opcode for the current slot
//   imem_operand - operand for the current slot
//   cpu_hold     - high keeps the processor in reset
//   loaded       - image loaded and checksum good
//   error        - sticky: length too large or checksum mismatch
//   word_count   - instruction count N taken from the frame header

module program_loader #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int DEPTH      = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  reload,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [DATA_WIDTH-1:0] imem_opcode,
  output logic [DATA_WIDTH-1:0] imem_operand,
  output logic                  cpu_hold,
  output logic                  loaded,
  output logic                  error,
  output logic [15:0]           word_count
);

  localparam logic [31:0] LP_DEPTH = 32'(DEPTH);

  typedef enum logic [3:0] {
    S_HDR_HI = 4'd0,
    S_HDR_LO = 4'd1,
    S_OPC_HI = 4'd2,
    S_OPC_LO = 4'd3,
    S_OPR_HI = 4'd4,
    S_OPR_LO = 4'd5,
    S_WRITE  = 4'd6,
    S_CSUM   = 4'd7,
    S_DONE   = 4'd8,
    S_ERROR  = 4'd9
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [7:0]  r_xor;
  logic        w_accept;
  logic        w_restart;
  logic [15:0] w_hdr_n;
  logic [31:0] w_addr_inc;

  // Full header count as seen in the HDR_LO cycle: high byte already latched,
  // low byte still on the input.
  assign w_hdr_n    = {word_count[15:8], in_data};
  assign w_addr_inc = 32'(imem_addr) + 32'd1;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_HDR_HI;
    end else begin
      r_state <= w_next_state;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_HDR_HI: if (w_accept) w_next_state = S_HDR_LO;
      S_HDR_LO: begin
        if (w_accept) begin
          if (32'(w_hdr_n) > LP_DEPTH) begin
            w_next_state = S_ERROR;
          end else if (w_hdr_n == 16'd0) begin
            w_next_state = S_CSUM;
          end else begin
            w_next_state = S_OPC_HI;
          end
        end
      end
      S_OPC_HI: if (w_accept) w_next_state = S_OPC_LO;
      S_OPC_LO: if (w_accept) w_next_state = S_OPR_HI;
      S_OPR_HI: if (w_accept) w_next_state = S_OPR_LO;
      S_OPR_LO: if (w_accept) w_next_state = S_WRITE;
      S_WRITE: begin
        // Compare the post-increment address against N; it is one bit wider than
        // imem_addr can hold when N == 2**ADDR_WIDTH.
        if (w_addr_inc == 32'(word_count)) begin
          w_next_state = S_CSUM;
        end else begin
          w_next_state = S_OPC_HI;
        end
      end
      S_CSUM: begin
        if (w_accept) begin
          w_next_state = (in_data == r_xor) ? S_DONE : S_ERROR;
        end
      end
      S_DONE:  if (reload) w_next_state = S_HDR_HI;
      S_ERROR: if (reload) w_next_state = S_HDR_HI;
      default: w_next_state = S_HDR_HI;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output decode
  // ---------------------------------------------------------------------------
  always_comb begin
    in_ready = 1'b0;
    case (r_state)
      S_HDR_HI, S_HDR_LO, S_OPC_HI, S_OPC_LO,
      S_OPR_HI, S_OPR_LO, S_CSUM: in_ready = 1'b1;
      default:                    in_ready = 1'b0;
    endcase
  end

  assign w_accept  = in_valid && in_ready;
  assign w_restart = reload && ((r_state == S_DONE) || (r_state == S_ERROR));

  // ---------------------------------------------------------------------------
  // Datapath and registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_xor        <= 8'd0;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_opcode  <= '0;
      imem_operand <= '0;
      word_count   <= 16'd0;
      cpu_hold     <= 1'b1;
      loaded       <= 1'b0;
      error        <= 1'b0;
    end else begin
      // Status flags follow the state being entered so they are valid in the
      // same cycle the FSM sits in WRITE / DONE / ERROR.
      imem_we  <= (w_next_state == S_WRITE);
      cpu_hold <= (w_next_state != S_DONE);
      loaded   <= (w_next_state == S_DONE);
      error    <= (w_next_state == S_ERROR);

      // The checksum byte itself is never folded into the running XOR.
      if (w_accept && (r_state != S_CSUM)) begin
        r_xor <= r_xor ^ in_data;
      end

      case (r_state)
        S_HDR_HI: if (w_accept) word_count[15:8] <= in_data;
        S_HDR_LO: if (w_accept) word_count[7:0]  <= in_data;
        S_OPC_HI, S_OPC_LO: begin
          if (w_accept) imem_opcode <= {imem_opcode[DATA_WIDTH-9:0], in_data};
        end
        S_OPR_HI, S_OPR_LO: begin
          if (w_accept) imem_operand <= {imem_operand[DATA_WIDTH-9:0], in_data};
        end
        S_WRITE: imem_addr <= imem_addr + ADDR_WIDTH'(1);
        S_DONE, S_ERROR: begin
          if (w_restart) begin
            imem_addr <= '0;
            r_xor     <= 8'd0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Byte-stream program loader that fills the processor's instruction memory before execution.
- Receives a framed image over a valid/ready byte interface and assembles 16-bit opcode/operand pairs.
- Writes one instruction word per slot and holds the processor in reset until the image is loaded and its checksum passes.
- It is the writer side of the instruction store that the processor fetch path reads.

Parameters:
DATA_WIDTH, 16, width of opcode and operand fields.
ADDR_WIDTH, 8, instruction memory address width.
DEPTH, 256, number of instruction slots; must be <= 2**ADDR_WIDTH.

Ports:
clk  input  1  system clock, all state on rising edge.
reset  input  1  asynchronous, active-high reset.
in_data  input  8  incoming image byte.
in_valid  input  1  in_data is valid.
in_ready  output  1  loader can accept a byte this cycle.
reload  input  1  single-cycle pulse; restarts loading from DONE or ERROR.
imem_we  output  1  instruction memory write strobe.
imem_addr  output  ADDR_WIDTH  write address.
imem_opcode  output  DATA_WIDTH  opcode to write.
imem_operand  output  DATA_WIDTH  operand to write.
cpu_hold  output  1  high keeps the processor in reset.
loaded  output  1  image loaded and checksum OK.
error  output  1  sticky: bad length or checksum mismatch.
word_count  output  16  instruction count N from the header.

Behaviour:
- Frame format, in byte order:
  - N high byte, N low byte.
  - N records, each 4 bytes: opcode hi, opcode lo, operand hi, operand lo.
  - One checksum byte equal to the XOR of every preceding frame byte, header included.
- A byte is accepted on a rising edge with in_valid && in_ready. in_data is ignored otherwise.
- States: HDR_HI, HDR_LO, OPC_HI, OPC_LO, OPR_HI, OPR_LO, WRITE, CSUM, DONE, ERROR.
- in_ready is 1 in HDR_HI, HDR_LO, OPC_HI, OPC_LO, OPR_HI, OPR_LO and CSUM, and 0 elsewhere. It is a decode of state.
- Reset (async):
  - state=HDR_HI, address counter=0, running XOR=0.
  - imem_we=0, imem_addr=0, imem_opcode=0, imem_operand=0, word_count=0.
  - cpu_hold=1, loaded=0, error=0.
  - Consequence: in_ready=1 from the first cycle after reset; the source must not assert in_valid during reset.
- Each accepted byte is XORed into the running checksum, except the CSUM byte itself.
- HDR_HI to HDR_LO on accept. HDR_HI latches word_count[15:8].
- HDR_LO on accept latches word_count[7:0], then branches on the full count N:
  - N > DEPTH: go to ERROR.
  - N == 0: go to CSUM.
  - Otherwise: go to OPC_HI.
- OPC_HI, OPC_LO, OPR_HI and OPR_LO shift bytes into imem_opcode/imem_operand, high byte first, then advance on accept. OPR_LO advances to WRITE.
- WRITE lasts exactly 1 cycle:
  - imem_we=1 with imem_addr = current address.
  - Opcode/operand are stable during this cycle.
  - Next edge: address increments. If the incremented address equals N, go to CSUM; else go to OPC_HI.
- imem_we is 0 in every state other than WRITE.
- Latency:
  - Per instruction: 4 accepted bytes plus 1 WRITE cycle.
  - Minimum frame: 2 + 5N + 1 cycles with in_valid held high.
- CSUM on accept: byte equals running XOR → DONE; otherwise → ERROR.
- DONE: loaded=1, cpu_hold=0. The state is held until reload.
- ERROR: error=1, cpu_hold=1, loaded=0. The state is held until reload or reset.
- reload, honoured only in DONE or ERROR:
  - Next state HDR_HI; address and XOR cleared.
  - cpu_hold=1, loaded=0, error=0.
  - reload in any other state is ignored.
- Address never wraps: N <= DEPTH guarantees the last write is at DEPTH-1.
- Reset mid-frame discards the partial frame. Memory contents already written are not cleared.
- Outputs imem_*, word_count, cpu_hold, loaded and error are registered.

Test Plan:
- Reset then frame 00 02 | 41 05 00 07 | 00 00 00 00 | 41, in_valid held high:
  - writes addr0 opcode 0x4105 operand 0x0007, then addr1 0x0000/0x0000;
  - loaded=1 and cpu_hold=0 exactly 13 cycles after the first byte is accepted.
- Same frame with checksum 0x40 → error=1, cpu_hold=1, loaded=0. Both writes occurred. in_ready=0 afterwards.
- Header 01 01 (N=257 > DEPTH) → ERROR immediately after the second byte. imem_we never asserted.
- Header 00 00 then checksum 00 → DONE with no writes. word_count=0.
- Frame with N=1 where in_valid toggles 1-0-1-0: bytes accepted only on valid cycles; the write and final result match the un-throttled run.
- From DONE, pulse reload and send a new N=1 frame 00 01 | 22 00 00 03 | 20:
  - cpu_hold rises the cycle after reload;
  - write at addr0 = 0x2200/0x0003;
  - DONE reached again.
  - Also: assert reset during the OPR_HI state of a frame → all outputs return to reset values immediately.
